game_round_fsm: RTL and testbench

- Runs one dice-race round between P1 and P2: players alternate turns, each roll moves the current player's piece one step at a time, and the round ends on goal arrival or when the turn limit runs out.
- Drives the round-result interface of the match tracker: a one-cycle `game_end` pulse plus `game_win`.
- Consumes the tracker's `next_match` and `final_state` to start later rounds.
- Piece positions and turn info feed the display/I2C path.

---
 rtl/game_round_fsm_if.sv | 40 ++++
 rtl/game_round_fsm.sv | 187 ++++++++++++++++++
 tb/tb_game_round_fsm.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_round_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_fsm_if
//  Description : Control and round-result bundle between the match tracker
//                and the dice-race round sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_round_fsm_if #(
    parameter int PW = 4
);
    logic          start;
    logic          next_match;
    logic          final_state;
    logic          restart;
    logic          roll;
    logic [2:0]    dice_val;
    logic          game_end;
    logic [1:0]    game_win;
    logic [PW-1:0] pos_p1;
    logic [PW-1:0] pos_p2;
    logic          cur_player;
    logic [3:0]    turn_no;
    logic          moving;
    logic          round_active;

    // Match tracker / player controls side
    modport master (
        output start, next_match, final_state, restart, roll, dice_val,
        input  game_end, game_win, pos_p1, pos_p2, cur_player, turn_no,
               moving, round_active
    );

    // Round sequencer side
    modport slave (
        input  start, next_match, final_state, restart, roll, dice_val,
        output game_end, game_win, pos_p1, pos_p2, cur_player, turn_no,
               moving, round_active
    );
endinterface
`default_nettype wire

// File: rtl/game_round_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_fsm
//  Description : One dice-race round between P1 and P2 with stepped piece
//                movement, goal clamp and turn limit; all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_round_fsm #(
    parameter int TRACK_LEN   = 15,
    parameter int MAX_TURNS   = 8,
    parameter int STEP_CYCLES = 10_000_000,
    parameter int PW          = $clog2(TRACK_LEN + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    game_round_fsm_if.slave  bus
);

    localparam int                 c_CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(STEP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [PW-1:0]      c_GOAL      = PW'(TRACK_LEN);
    localparam logic [PW-1:0]      c_POS_ONE   = PW'(1);
    localparam logic [3:0]         c_LAST_TURN = 4'(MAX_TURNS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ROLL = 3'd1,
        S_MOVE      = 3'd2,
        S_CHECK     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             r_state, w_state;
    logic [c_CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]         r_steps, w_steps;
    logic [PW-1:0]      r_pos_p1, w_pos_p1;
    logic [PW-1:0]      r_pos_p2, w_pos_p2;
    logic               r_cur_player, w_cur_player;
    logic [3:0]         r_turn_no, w_turn_no;
    logic               r_moving, w_moving;
    logic               r_round_active, w_round_active;
    logic               r_game_end, w_game_end;
    logic [1:0]         r_game_win, w_game_win;

    logic [PW-1:0]      w_cur_pos;
    logic [PW-1:0]      w_cur_pos_inc;
    logic               w_start_req;
    logic               w_dice_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_steps        <= '0;
            r_pos_p1       <= '0;
            r_pos_p2       <= '0;
            r_cur_player   <= 1'b0;
            r_turn_no      <= '0;
            r_moving       <= 1'b0;
            r_round_active <= 1'b0;
            r_game_end     <= 1'b0;
            r_game_win     <= 2'b00;
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_steps        <= w_steps;
            r_pos_p1       <= w_pos_p1;
            r_pos_p2       <= w_pos_p2;
            r_cur_player   <= w_cur_player;
            r_turn_no      <= w_turn_no;
            r_moving       <= w_moving;
            r_round_active <= w_round_active;
            r_game_end     <= w_game_end;
            r_game_win     <= w_game_win;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_cnt          = r_cnt;
        w_steps        = r_steps;
        w_pos_p1       = r_pos_p1;
        w_pos_p2       = r_pos_p2;
        w_cur_player   = r_cur_player;
        w_turn_no      = r_turn_no;
        w_moving       = r_moving;
        w_round_active = r_round_active;
        w_game_end     = 1'b0;
        w_game_win     = r_game_win;

        w_cur_pos      = r_cur_player ? r_pos_p2 : r_pos_p1;
        w_cur_pos_inc  = w_cur_pos + c_POS_ONE;
        w_start_req    = (bus.start | bus.next_match) & ~bus.final_state;
        w_dice_ok      = (bus.dice_val != 3'd0) && (bus.dice_val != 3'd7);

        if (bus.restart) begin
            w_state        = S_IDLE;
            w_cnt          = '0;
            w_steps        = '0;
            w_pos_p1       = '0;
            w_pos_p2       = '0;
            w_cur_player   = 1'b0;
            w_turn_no      = '0;
            w_moving       = 1'b0;
            w_round_active = 1'b0;
            w_game_win     = 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_req) begin
                        w_state        = S_WAIT_ROLL;
                        w_round_active = 1'b1;
                        w_game_win     = 2'b00;
                    end
                end
                S_WAIT_ROLL: begin
                    if (bus.roll && w_dice_ok) begin
                        w_steps  = bus.dice_val;
                        w_cnt    = '0;
                        w_moving = 1'b1;
                        w_state  = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt   = '0;
                        w_steps = r_steps - 3'd1;
                        if (r_cur_player) w_pos_p2 = w_cur_pos_inc;
                        else              w_pos_p1 = w_cur_pos_inc;
                        // Reaching the goal cuts the move short even with steps left
                        if ((r_steps <= 3'd1) || (w_cur_pos_inc == c_GOAL)) begin
                            w_moving = 1'b0;
                            w_state  = S_CHECK;
                        end
                    end else begin
                        w_cnt = r_cnt + c_CNT_ONE;
                    end
                end
                S_CHECK: begin
                    if (w_cur_pos == c_GOAL) begin
                        w_state        = S_DONE;
                        w_game_end     = 1'b1;
                        w_round_active = 1'b0;
                        w_game_win     = r_cur_player ? 2'b10 : 2'b01;
                    end else if (r_cur_player && (r_turn_no == c_LAST_TURN)) begin
                        w_state        = S_DONE;
                        w_game_end     = 1'b1;
                        w_round_active = 1'b0;
                        if (r_pos_p1 > r_pos_p2)      w_game_win = 2'b01;
                        else if (r_pos_p2 > r_pos_p1) w_game_win = 2'b10;
                        else                          w_game_win = 2'b00;
                    end else begin
                        w_cur_player = ~r_cur_player;
                        if (r_cur_player) w_turn_no = r_turn_no + 4'd1;
                        w_state      = S_WAIT_ROLL;
                    end
                end
                S_DONE: begin
                    if (bus.next_match && !bus.final_state) begin
                        w_pos_p1       = '0;
                        w_pos_p2       = '0;
                        w_cur_player   = 1'b0;
                        w_turn_no      = '0;
                        w_game_win     = 2'b00;
                        w_round_active = 1'b1;
                        w_state        = S_WAIT_ROLL;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign bus.game_end     = r_game_end;
    assign bus.game_win     = r_game_win;
    assign bus.pos_p1       = r_pos_p1;
    assign bus.pos_p2       = r_pos_p2;
    assign bus.cur_player   = r_cur_player;
    assign bus.turn_no      = r_turn_no;
    assign bus.moving       = r_moving;
    assign bus.round_active = r_round_active;

endmodule
`default_nettype wire

// File: tb/tb_game_round_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_round_fsm
//  Description : Self-checking bench for game_round_fsm using a table of
//                per-turn expectations plus directed corner-case sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_fsm;

    localparam int TRACK_LEN   = 15;
    localparam int MAX_TURNS   = 3;
    localparam int STEP_CYCLES = 4;
    localparam int PW          = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    game_round_fsm_if #(.PW(PW)) bus ();

    game_round_fsm #(
        .TRACK_LEN   (TRACK_LEN),
        .MAX_TURNS   (MAX_TURNS),
        .STEP_CYCLES (STEP_CYCLES),
        .PW          (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dice;
        bit mid_roll;
        int mov;
        int p1, p2, cp, tn, ends, win, act;
    } turn_t;

    turn_t tv [26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Roll, follow the stepping cycle by cycle, then compare the settled state.
    task automatic play_turn(input int idx);
        turn_t v;
        int who, base, k, ends, bad, pos;
        v    = tv[idx];
        who  = int'(bus.cur_player);
        base = who ? int'(bus.pos_p2) : int'(bus.pos_p1);
        @(negedge clk); bus.roll = 1'b1; bus.dice_val = 3'(v.dice);
        @(negedge clk); bus.roll = 1'b0; bus.dice_val = 3'd0;
        k = 0; ends = 0; bad = 0;
        for (int n = 0; n < 400 && bus.moving; n++) begin
            k++;
            pos = who ? int'(bus.pos_p2) : int'(bus.pos_p1);
            if (pos != base + (k - 1) / STEP_CYCLES) bad++;
            ends += int'(bus.game_end);
            if (v.mid_roll && k == 6) begin bus.roll = 1'b1; bus.dice_val = 3'd6; end
            else bus.roll = 1'b0;
            @(negedge clk);
        end
        bus.roll = 1'b0;
        ends += int'(bus.game_end);
        @(negedge clk);
        ends += int'(bus.game_end);
        check($sformatf("t%0d moving_cycles", idx), k, v.mov);
        check($sformatf("t%0d step_timing", idx), bad, 0);
        check($sformatf("t%0d pos_p1", idx), bus.pos_p1, v.p1);
        check($sformatf("t%0d pos_p2", idx), bus.pos_p2, v.p2);
        check($sformatf("t%0d cur_player", idx), bus.cur_player, v.cp);
        check($sformatf("t%0d turn_no", idx), bus.turn_no, v.tn);
        check($sformatf("t%0d game_win", idx), bus.game_win, v.win);
        check($sformatf("t%0d round_active", idx), bus.round_active, v.act);
        @(negedge clk);
        ends += int'(bus.game_end);
        check($sformatf("t%0d game_end_pulses", idx), ends, v.ends);
    endtask

    task automatic new_round(input int idx);
        @(negedge clk); bus.next_match = 1'b1;
        @(negedge clk); bus.next_match = 1'b0;
        check($sformatf("nm%0d pos_p1", idx), bus.pos_p1, 0);
        check($sformatf("nm%0d pos_p2", idx), bus.pos_p2, 0);
        check($sformatf("nm%0d game_win", idx), bus.game_win, 0);
        check($sformatf("nm%0d round_active", idx), bus.round_active, 1);
        check($sformatf("nm%0d cur_player", idx), bus.cur_player, 0);
        check($sformatf("nm%0d turn_no", idx), bus.turn_no, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " round_active"}, bus.round_active, 0);
        check({tag, " moving"}, bus.moving, 0);
        check({tag, " game_end"}, bus.game_end, 0);
        check({tag, " game_win"}, bus.game_win, 0);
        check({tag, " pos_p1"}, bus.pos_p1, 0);
        check({tag, " pos_p2"}, bus.pos_p2, 0);
        check({tag, " cur_player"}, bus.cur_player, 0);
        check({tag, " turn_no"}, bus.turn_no, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ends;
        //        dice mid mov  p1  p2 cp tn end win act
        tv[0]  = '{5, 0, 20,  5,  0, 1, 0, 0, 0, 1};
        tv[1]  = '{1, 0,  4,  5,  1, 0, 1, 0, 0, 1};
        tv[2]  = '{6, 1, 24, 11,  1, 1, 1, 0, 0, 1};
        tv[3]  = '{2, 0,  8, 11,  3, 0, 2, 0, 0, 1};
        tv[4]  = '{6, 0, 16, 15,  3, 0, 2, 1, 1, 0};
        tv[5]  = '{2, 0,  8,  2,  0, 1, 0, 0, 0, 1};
        tv[6]  = '{3, 0, 12,  2,  3, 0, 1, 0, 0, 1};
        tv[7]  = '{2, 0,  8,  4,  3, 1, 1, 0, 0, 1};
        tv[8]  = '{3, 0, 12,  4,  6, 0, 2, 0, 0, 1};
        tv[9]  = '{2, 0,  8,  6,  6, 1, 2, 0, 0, 1};
        tv[10] = '{3, 0, 12,  6,  9, 1, 2, 1, 2, 0};
        tv[11] = '{2, 0,  8,  2,  0, 1, 0, 0, 0, 1};
        tv[12] = '{2, 0,  8,  2,  2, 0, 1, 0, 0, 1};
        tv[13] = '{2, 0,  8,  4,  2, 1, 1, 0, 0, 1};
        tv[14] = '{2, 0,  8,  4,  4, 0, 2, 0, 0, 1};
        tv[15] = '{2, 0,  8,  6,  4, 1, 2, 0, 0, 1};
        tv[16] = '{2, 0,  8,  6,  6, 1, 2, 1, 0, 0};
        tv[17] = '{4, 0, 16,  4,  0, 1, 0, 0, 0, 1};
        tv[18] = '{1, 0,  4,  4,  1, 0, 1, 0, 0, 1};
        tv[19] = '{4, 0, 16,  8,  1, 1, 1, 0, 0, 1};
        tv[20] = '{1, 0,  4,  8,  2, 0, 2, 0, 0, 1};
        tv[21] = '{4, 0, 16, 12,  2, 1, 2, 0, 0, 1};
        tv[22] = '{1, 0,  4, 12,  3, 1, 2, 1, 1, 0};
        tv[23] = '{1, 0,  4,  1,  0, 1, 0, 0, 0, 1};
        tv[24] = '{5, 0, 20,  1,  5, 0, 1, 0, 0, 1};
        tv[25] = '{1, 0,  4,  2,  5, 1, 1, 0, 0, 1};

        bus.start = 1'b0; bus.next_match = 1'b0; bus.final_state = 1'b0;
        bus.restart = 1'b0; bus.roll = 1'b0; bus.dice_val = 3'd0;

        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // Roll while idle must not move anything
        @(negedge clk); bus.roll = 1'b1; bus.dice_val = 3'd4;
        @(negedge clk); bus.roll = 1'b0;
        check("idle_roll moving", bus.moving, 0);

        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check("start round_active", bus.round_active, 1);
        check("start cur_player", bus.cur_player, 0);
        check("start moving", bus.moving, 0);

        @(negedge clk); bus.roll = 1'b1; bus.dice_val = 3'd0;
        @(negedge clk); bus.roll = 1'b0;
        check("dice0 moving", bus.moving, 0);
        @(negedge clk); bus.roll = 1'b1; bus.dice_val = 3'd7;
        @(negedge clk); bus.roll = 1'b0;
        check("dice7 moving", bus.moving, 0);
        repeat (6) @(negedge clk);
        check("dice_bad pos_p1", bus.pos_p1, 0);

        for (int i = 0; i < 26; i++) begin
            if (i == 5) begin
                // Match over: further round starts are blocked
                @(negedge clk); bus.final_state = 1'b1; bus.next_match = 1'b1; bus.start = 1'b1;
                @(negedge clk); bus.next_match = 1'b0; bus.start = 1'b0;
                @(negedge clk);
                check("final round_active", bus.round_active, 0);
                check("final pos_p1", bus.pos_p1, 15);
                check("final game_win", bus.game_win, 1);
                check("final game_end", bus.game_end, 0);
                bus.final_state = 1'b0;
            end
            if (i == 5 || i == 11 || i == 17 || i == 23) new_round(i);
            play_turn(i);
        end

        // Abort mid-move once P2 reaches square 7
        @(negedge clk); bus.roll = 1'b1; bus.dice_val = 3'd6;
        @(negedge clk); bus.roll = 1'b0;
        for (int n = 0; n < 100 && bus.pos_p2 != 4'd7; n++) @(negedge clk);
        check("abort reach pos_p2", bus.pos_p2, 7);
        check("abort moving_before", bus.moving, 1);
        bus.restart = 1'b1;
        @(negedge clk); bus.restart = 1'b0;
        check_cleared("abort");
        ends = 0;
        repeat (30) begin
            @(negedge clk);
            ends += int'(bus.game_end);
        end
        check("abort game_end_pulses", ends, 0);
        check("abort idle pos_p2", bus.pos_p2, 0);

        // Restart beats a simultaneous roll
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check("restart2 started", bus.round_active, 1);
        bus.restart = 1'b1; bus.roll = 1'b1; bus.dice_val = 3'd3;
        @(negedge clk); bus.restart = 1'b0; bus.roll = 1'b0;
        check("restart_roll moving", bus.moving, 0);
        check("restart_roll round_active", bus.round_active, 0);
        repeat (8) @(negedge clk);
        check("restart_roll pos_p1", bus.pos_p1, 0);

        // Restart beats a simultaneous start
        bus.restart = 1'b1; bus.start = 1'b1;
        @(negedge clk); bus.restart = 1'b0; bus.start = 1'b0;
        check("restart_start round_active", bus.round_active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
